// File: rtl/prediction_stat_tracker_pkg.sv
// Shared trend encodings and counter-init helper for the predictor statistics tracker.
// No logic of its own; imported by the tracker top and its per-predictor channels.
package prediction_stat_tracker_pkg;

  localparam logic [3:0] TREND_COLD    = 4'b0001;
  localparam logic [3:0] TREND_FALLING = 4'b0010;
  localparam logic [3:0] TREND_STEADY  = 4'b0100;
  localparam logic [3:0] TREND_RISING  = 4'b1000;

  // State encoding is the one-hot trend itself, so the decode output is the state register.
  typedef enum logic [3:0] {
    ST_COLD    = TREND_COLD,
    ST_FALLING = TREND_FALLING,
    ST_STEADY  = TREND_STEADY,
    ST_RISING  = TREND_RISING
  } trend_state_e;

  function automatic int unsigned counter_init(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/stat_channel.sv
// One predictor's saturating confidence counter, warm-up streak and trend FSM.
// Registered outputs, 1-cycle latency; accepts an update every cycle, no backpressure.
module stat_channel
  import prediction_stat_tracker_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int WARMUP = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             update,
  input  logic             correct,
  input  logic             decay,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       trend_decode
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(counter_init(CNT_W));
  localparam logic [2:0]       STREAK_TGT = 3'(WARMUP);

  trend_state_e     state_q, state_d;
  logic [2:0]       streak_q, streak_d;
  logic [CNT_W-1:0] count_q, count_d, sat_cnt;

  always_comb begin
    sat_cnt  = count_q;
    streak_d = '0;
    if (correct) begin
      if (count_q != CNT_MAX) sat_cnt = count_q + CNT_W'(1);
      streak_d = (streak_q == STREAK_TGT) ? streak_q : streak_q + 3'd1;
    end else if (count_q != '0) begin
      sat_cnt = count_q - CNT_W'(1);
    end
    count_d = decay ? (sat_cnt >> 1) : sat_cnt;

    // Trend decisions use the pre-decay count so decay never moves the FSM.
    state_d = state_q;
    case (state_q)
      ST_COLD:    if (streak_d == STREAK_TGT) state_d = ST_STEADY;
      ST_STEADY:  state_d = correct ? ST_RISING : ST_FALLING;
      ST_RISING:  state_d = correct ? ST_RISING : ST_STEADY;
      ST_FALLING: begin
        if (correct) begin
          state_d = ST_STEADY;
        end else if (sat_cnt == '0) begin
          state_d  = ST_COLD;
          streak_d = '0;
        end
      end
      default:    state_d = ST_COLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_COLD;
      streak_q <= '0;
      count_q  <= CNT_INIT;
    end else if (update) begin
      state_q  <= state_d;
      streak_q <= streak_d;
      count_q  <= count_d;
    end
  end

  assign count        = count_q;
  assign trend_decode = state_q;

endmodule

// File: rtl/prediction_stat_tracker.sv
// Scores SP/LHP/GHP on each resolved branch and keeps their confidence, trend and periodic decay.
// Outputs registered, visible the cycle after a resolve; one resolve per cycle, never stalls.
module prediction_stat_tracker
  import prediction_stat_tracker_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int DECAY_PERIOD_WIDTH = 8,
  parameter int WARMUP_STREAK      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stat_clear,
  input  logic                          resolve_valid,
  input  logic                          resolve_taken,
  input  logic                          resolve_SP_pred,
  input  logic                          resolve_LHP_pred,
  input  logic                          resolve_GHP_pred,
  output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
  output logic [3:0]                    SP_trend_decode,
  output logic [3:0]                    LHP_trend_decode,
  output logic [3:0]                    GHP_trend_decode,
  output logic                          decay_pulse
);

  logic                          clear, update, decay;
  logic                          sp_correct, lhp_correct, ghp_correct;
  logic [DECAY_PERIOD_WIDTH-1:0] decay_cnt_q;

  // A clear in the same cycle as a resolve drops the resolve entirely.
  assign clear       = rst | stat_clear;
  assign update      = resolve_valid & ~clear;
  assign decay       = update & (&decay_cnt_q);
  assign sp_correct  = (resolve_SP_pred  == resolve_taken);
  assign lhp_correct = (resolve_LHP_pred == resolve_taken);
  assign ghp_correct = (resolve_GHP_pred == resolve_taken);

  always_ff @(posedge clk) begin
    if (clear) begin
      decay_cnt_q <= '0;
      decay_pulse <= 1'b0;
    end else begin
      decay_pulse <= decay;
      if (update) decay_cnt_q <= decay_cnt_q + DECAY_PERIOD_WIDTH'(1);
    end
  end

  stat_channel #(.CNT_W(STAT_COUNTER_WIDTH), .WARMUP(WARMUP_STREAK)) u_sp (
    .clk(clk), .clear(clear), .update(update), .correct(sp_correct), .decay(decay),
    .count(SP_stat_count), .trend_decode(SP_trend_decode)
  );

  stat_channel #(.CNT_W(STAT_COUNTER_WIDTH), .WARMUP(WARMUP_STREAK)) u_lhp (
    .clk(clk), .clear(clear), .update(update), .correct(lhp_correct), .decay(decay),
    .count(LHP_stat_count), .trend_decode(LHP_trend_decode)
  );

  stat_channel #(.CNT_W(STAT_COUNTER_WIDTH), .WARMUP(WARMUP_STREAK)) u_ghp (
    .clk(clk), .clear(clear), .update(update), .correct(ghp_correct), .decay(decay),
    .count(GHP_stat_count), .trend_decode(GHP_trend_decode)
  );

endmodule

// File: tb/tb_prediction_stat_tracker.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a random run vs a model.
module tb_prediction_stat_tracker;

  logic       clk;
  logic       rst, stat_clear, resolve_valid, resolve_taken;
  logic       sp_pred, lhp_pred, ghp_pred;
  logic [4:0] sp_cnt, lhp_cnt, ghp_cnt;
  logic [3:0] sp_tr, lhp_tr, ghp_tr;
  logic       decay_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: trend index 0 COLD, 1 FALLING, 2 STEADY, 3 RISING (one-hot bit position).
  int m_cnt[3];
  int m_streak[3];
  int m_tr[3];
  int m_resolves;
  int m_pulse;

  prediction_stat_tracker dut (
    .clk(clk), .rst(rst), .stat_clear(stat_clear),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_SP_pred(sp_pred), .resolve_LHP_pred(lhp_pred), .resolve_GHP_pred(ghp_pred),
    .SP_stat_count(sp_cnt), .LHP_stat_count(lhp_cnt), .GHP_stat_count(ghp_cnt),
    .SP_trend_decode(sp_tr), .LHP_trend_decode(lhp_tr), .GHP_trend_decode(ghp_tr),
    .decay_pulse(decay_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic clr, input logic v, input logic t, input logic [2:0] p);
    int  n;
    bit  dec;
    bit  ok;
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 16; m_streak[i] = 0; m_tr[i] = 0;
      end
      m_resolves = 0;
      m_pulse    = 0;
      return;
    end
    m_pulse = 0;
    if (!v) return;
    m_resolves++;
    dec = (m_resolves % 256) == 0;
    m_pulse = dec ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      ok = (p[i] == t);
      n  = ok ? ((m_cnt[i] + 1 > 31) ? 31 : m_cnt[i] + 1) : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
      m_streak[i] = ok ? ((m_streak[i] + 1 > 4) ? 4 : m_streak[i] + 1) : 0;
      case (m_tr[i])
        0: if (m_streak[i] == 4) m_tr[i] = 2;
        2: m_tr[i] = ok ? 3 : 1;
        3: m_tr[i] = ok ? 3 : 2;
        default: begin
          if (ok) m_tr[i] = 2;
          else if (n == 0) begin m_tr[i] = 0; m_streak[i] = 0; end
        end
      endcase
      m_cnt[i] = dec ? n / 2 : n;
    end
  endtask

  task automatic check_model();
    chk("sp_count",    sp_cnt,      m_cnt[0]);
    chk("lhp_count",   lhp_cnt,     m_cnt[1]);
    chk("ghp_count",   ghp_cnt,     m_cnt[2]);
    chk("sp_trend",    sp_tr,       1 << m_tr[0]);
    chk("lhp_trend",   lhp_tr,      1 << m_tr[1]);
    chk("ghp_trend",   ghp_tr,      1 << m_tr[2]);
    chk("decay_pulse", decay_pulse, m_pulse);
  endtask

  // p[0]=SP, p[1]=LHP, p[2]=GHP predictions.
  task automatic step(input logic r, input logic c, input logic v, input logic t, input logic [2:0] p);
    rst = r; stat_clear = c; resolve_valid = v; resolve_taken = t;
    sp_pred = p[0]; lhp_pred = p[1]; ghp_pred = p[2];
    @(posedge clk);
    #1;
    model_step(r | c, v, t, p);
    check_model();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  typedef struct {
    logic       sp_ok;
    int         exp_cnt;
    logic [3:0] exp_tr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic       r, c, v, t;
    logic [2:0] p;
    int         pct[3];

    vecs[0] = '{1'b1, 17, 4'b0001};
    vecs[1] = '{1'b1, 18, 4'b0001};
    vecs[2] = '{1'b1, 19, 4'b0001};
    vecs[3] = '{1'b1, 20, 4'b0100};
    vecs[4] = '{1'b1, 21, 4'b1000};
    vecs[5] = '{1'b0, 20, 4'b0100};
    vecs[6] = '{1'b0, 19, 4'b0010};

    rst = 1'b1; stat_clear = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    sp_pred = 1'b0; lhp_pred = 1'b0; ghp_pred = 1'b0;

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    chk("rst_sp_count", sp_cnt, 16);
    chk("rst_lhp_count", lhp_cnt, 16);
    chk("rst_ghp_count", ghp_cnt, 16);
    chk("rst_sp_trend", sp_tr, 4'b0001);
    chk("rst_ghp_trend", ghp_tr, 4'b0001);
    chk("rst_decay_pulse", decay_pulse, 0);

    // SP warm-up / rise / fall table.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, {2'b11, vecs[i].sp_ok});
      chk($sformatf("vec%0d_sp_count", i), sp_cnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_sp_trend", i), sp_tr, vecs[i].exp_tr);
    end

    // LHP wrong 16 then 17 times: saturates at 0, stays COLD.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'b101);
      if (i == 16) begin
        chk("lhp_floor_count", lhp_cnt, 0);
        chk("lhp_floor_trend", lhp_tr, 4'b0001);
      end
    end
    chk("lhp_sat_count", lhp_cnt, 0);
    chk("lhp_sat_trend", lhp_tr, 4'b0001);

    // GHP correct 256 times: saturation then decay on the 256th.
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'b100);
      if (i == 15)  chk("ghp_sat15_count", ghp_cnt, 31);
      if (i == 255) begin
        chk("ghp_pre_decay_count", ghp_cnt, 31);
        chk("ghp_pre_decay_pulse", decay_pulse, 0);
      end
    end
    chk("ghp_decay_count", ghp_cnt, 15);
    chk("ghp_decay_pulse", decay_pulse, 1);
    chk("ghp_decay_trend", ghp_tr, 4'b1000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    chk("ghp_pulse_one_cycle", decay_pulse, 0);
    chk("ghp_hold_count", ghp_cnt, 15);

    // SP: STEADY -> FALLING -> count 0 -> COLD, then re-warm.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'b111);
    chk("sp_steady_trend", sp_tr, 4'b0100);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'b110);
    chk("sp_falling_trend", sp_tr, 4'b0010);
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'b110);
      if (i == 17) chk("sp_fall_near_zero_trend", sp_tr, 4'b0010);
    end
    chk("sp_cold_count", sp_cnt, 0);
    chk("sp_cold_trend", sp_tr, 4'b0001);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'b111);
    chk("sp_rewarm3_trend", sp_tr, 4'b0001);
    chk("sp_rewarm3_count", sp_cnt, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'b111);
    chk("sp_rewarm4_trend", sp_tr, 4'b0100);

    // Random run against the model, with a forced clear+resolve collision midway.
    pct[0] = 50; pct[1] = 80; pct[2] = 95;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      c = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 3) != 0);
      t = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) p[k] = ($urandom_range(0, 99) < pct[k]) ? t : ~t;
      if (i == 1500) begin
        step(1'b0, 1'b1, 1'b1, t, p);
        chk("clr_sp_count", sp_cnt, 16);
        chk("clr_lhp_count", lhp_cnt, 16);
        chk("clr_ghp_count", ghp_cnt, 16);
        chk("clr_lhp_trend", lhp_tr, 4'b0001);
        chk("clr_pulse", decay_pulse, 0);
      end else begin
        step(r, c, v, t, p);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prediction_stat_tracker.md
# prediction_stat_tracker

Maintains the per-predictor accuracy statistics that the branch prediction arbiter uses to choose between the static (SP), local-history (LHP) and global-history (GHP) predictors. On every resolved branch it scores each predictor, updates saturating confidence counters, runs a per-predictor trend state machine and applies periodic decay. It sits beside the arbiter in the fetch/branch unit. It is fed from the branch-resolution stage and drives the arbiter's `*_stat_count` and `*_trend_decode` inputs.

## Interface
- `STAT_COUNTER_WIDTH`, 5: width of each confidence counter; must match the arbiter.
- `DECAY_PERIOD_WIDTH`, 8: decay fires once every 2^DECAY_PERIOD_WIDTH resolves.
- `WARMUP_STREAK`, 4: consecutive correct predictions required to leave COLD; range 1..7.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stat_clear`  in  1  synchronous soft clear (pipeline-wide predictor flush); same effect as `rst`.
- `resolve_valid`  in  1  one branch resolved this cycle.
- `resolve_taken`  in  1  actual branch outcome.
- `resolve_SP_pred`, `resolve_LHP_pred`, `resolve_GHP_pred`  in  1 each  prediction each predictor made for this branch, carried down the pipe.
- `SP_stat_count`, `LHP_stat_count`, `GHP_stat_count`  out  STAT_COUNTER_WIDTH each  confidence counters.
- `SP_trend_decode`, `LHP_trend_decode`, `GHP_trend_decode`  out  4 each  one-hot trend: [0] COLD, [1] FALLING, [2] STEADY, [3] RISING.
- `decay_pulse`  out  1  high for one cycle after a decay was applied.

## Operation
- Per predictor X, on each `resolve_valid` cycle: correct = (resolve_X_pred == resolve_taken).
- Counter update: correct → +1, saturating at 2^W−1. Wrong → −1, saturating at 0.
- Decay counter: DECAY_PERIOD_WIDTH bits, resets to 0, increments on each `resolve_valid` and wraps.
  - When it is all-ones on a `resolve_valid` cycle (the 2^DECAY_PERIOD_WIDTH-th resolve), each counter becomes (saturated update) >> 1, in the same cycle.
  - Decay does not affect trend state or streak counters.
- Streak counter, per predictor, 3 bits: correct → increment, saturating at WARMUP_STREAK; wrong → 0.
- Trend FSM, per predictor, evaluated only on `resolve_valid`:
  - COLD: exits to STEADY when the post-update streak equals WARMUP_STREAK; otherwise stays COLD.
  - STEADY: correct → RISING; wrong → FALLING.
  - RISING: correct → RISING; wrong → STEADY.
  - FALLING: correct → STEADY; wrong → FALLING, except wrong with a post-update counter of 0 → COLD, with the streak cleared.
- Counters update in every state, including COLD. The arbiter masks the COLD count itself.
- No `resolve_valid`: all state holds.
- `rst` or `stat_clear`:
  - counters = 2^(W−1), i.e. 16 for W=5;
  - trends = COLD (4'b0001);
  - streaks = 0, decay counter = 0, `decay_pulse` = 0.
- `rst`/`stat_clear` asserted together with `resolve_valid`: clear wins and the resolve is dropped.

## Timing
- All outputs are registered. A resolve in cycle N is visible on the outputs in cycle N+1.
- Back-to-back resolves every cycle are supported, with no stall and no handshake back-pressure.
- `decay_pulse` is high in cycle N+1 for a decaying resolve in cycle N.
- Reset values hold until the first resolve after reset or clear deasserts.

## Structure
- Shared package holds:
  - trend one-hot constants `TREND_COLD`=4'b0001, `TREND_FALLING`=4'b0010, `TREND_STEADY`=4'b0100, `TREND_RISING`=4'b1000;
  - the trend-state encoding;
  - the counter init expression.
- Sub-module `stat_channel`, instantiated three times: one predictor's counter, streak and trend FSM. Inputs are `correct`, `update`, `decay`, `clear`.
- The top level owns the decay counter, the `decay_pulse` register and the correctness compares.

## Test plan
Defaults W=5, DECAY_PERIOD_WIDTH=8, WARMUP_STREAK=4.
- Reset then idle → all counts 16, all trends 4'b0001, `decay_pulse` 0.
- 4 resolves with SP correct → SP count 17,18,19,20 and trend 4'b0100 after the 4th.
  - 5th correct → 21 and 4'b1000.
  - Then wrong → 20 and 4'b0100.
  - Then wrong → 19 and 4'b0010.
- LHP wrong 16 times from reset → count reaches 0 and trend stays COLD. A 17th wrong → count stays 0 (saturation).
- GHP correct 256 times from reset:
  - count reaches 31 by the 15th resolve and holds;
  - on the 256th, count becomes 15 and `decay_pulse` is 1 for one cycle;
  - trend stays RISING.
- Drive SP to STEADY then FALLING, then wrong predictions until the count hits 0 → trend COLD. Then 3 correct → still COLD; 4th correct → STEADY.
- Mid-run `stat_clear` together with `resolve_valid` → next cycle all counts 16, trends COLD, and the dropped resolve has no effect.
